return_stack: RTL

RETURN_STACK -- requirements
Module: return_stack

---
 rtl/return_stack_pkg.sv | 17 +
 rtl/stack_mem.sv | 25 ++
 rtl/return_stack.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/return_stack_pkg.sv
// Shared definitions for the return stack: CPU word width, default depth and operation decode.
package return_stack_pkg;

  localparam int unsigned WORD_WIDTH    = 16;
  localparam int unsigned DEFAULT_DEPTH = 8;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_SWAP,
    OP_BYPASS,
    OP_UNDER,
    OP_OVER
  } rs_op_e;

endpackage

// File: rtl/stack_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one combinational read port.
module stack_mem #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Contents are never reset; they are only observable through a non-empty stack.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/return_stack.sv
// Circular-buffer return stack feeding the PC load port.
// Optional macro RETURN_STACK_WRAP_EN: a push when full overwrites the oldest entry.
module return_stack
  import return_stack_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           out_addr,
  output logic                       out_load,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [PW-1:0]    r_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_out_addr;
  logic             r_out_load;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_empty;
  logic             w_full;
  logic [PW-1:0]    w_top_idx;
  logic [WIDTH-1:0] w_rd_data;
  logic             w_we;
  logic [PW-1:0]    w_waddr;
  rs_op_e           w_op;

  // r_ptr is the next free slot; the top entry sits one below it.
  assign w_top_idx = r_ptr - PW'(1);
  assign w_empty   = (r_count == CW'(0));
  assign w_full    = (r_count == CW'(DEPTH));

  always_comb begin
    w_op = OP_IDLE;
    if (push && pop) begin
      w_op = w_empty ? OP_BYPASS : OP_SWAP;
    end else if (pop) begin
      w_op = w_empty ? OP_UNDER : OP_POP;
    end else if (push) begin
      w_op = w_full ? OP_OVER : OP_PUSH;
    end
  end

  // Write port: a swap replaces the top in place, a wrapping push lands on the oldest slot.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_ptr;
    case (w_op)
      OP_PUSH: w_we = 1'b1;
      OP_SWAP: begin
        w_we    = 1'b1;
        w_waddr = w_top_idx;
      end
`ifdef RETURN_STACK_WRAP_EN
      OP_OVER: w_we = 1'b1;
`endif
      default: w_we = 1'b0;
    endcase
    if (reset) begin
      w_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr       <= '0;
      r_count     <= '0;
      r_out_addr  <= '0;
      r_out_load  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_out_load <= 1'b0;
      case (w_op)
        OP_PUSH: begin
          r_ptr   <= r_ptr + PW'(1);
          r_count <= r_count + CW'(1);
        end
        OP_POP: begin
          r_out_addr <= w_rd_data;
          r_out_load <= 1'b1;
          r_ptr      <= w_top_idx;
          r_count    <= r_count - CW'(1);
        end
        OP_SWAP: begin
          r_out_addr <= w_rd_data;
          r_out_load <= 1'b1;
        end
        OP_BYPASS: begin
          r_out_addr <= push_data;
          r_out_load <= 1'b1;
        end
        OP_UNDER: r_underflow <= 1'b1;
        OP_OVER: begin
          r_overflow <= 1'b1;
`ifdef RETURN_STACK_WRAP_EN
          r_ptr      <= r_ptr + PW'(1);
`endif
        end
        default: r_out_load <= 1'b0;
      endcase
    end
  end

  stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (push_data),
    .i_raddr (w_top_idx),
    .o_rdata (w_rd_data)
  );

  assign out_addr  = r_out_addr;
  assign out_load  = r_out_load;
  assign top       = w_empty ? '0 : w_rd_data;
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule
